fifo_canal: RTL

Synchronous per-channel FIFO placed directly downstream of the 4-way demux; one instance per demux output (salida0..salida3). It buffers the data words routed to its channel and presents them to the consumer with a registered pop interface. It also provides full/empty and programmable almost-full/almost-empty flags for upstream flow control, plus sticky overflow/underflow error flags.

---
 rtl/fifo_canal.sv | 93 +++++++++
 1 files changed

// File: rtl/fifo_canal.sv
// Per-channel FIFO sitting behind one demux output: buffers routed words and
// hands them to the consumer through a registered, one-cycle-latency pop port.
module fifo_canal #(
  parameter int DATA_BITS   = 4,
  parameter int ADDR_BITS   = 2,
  parameter int UMBRAL_ALTO = 3,
  parameter int UMBRAL_BAJO = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enb,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] dato_entrada,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dato_salida,
  output logic                 valido_salida,
  output logic                 lleno,
  output logic                 vacio,
  output logic                 casi_lleno,
  output logic                 casi_vacio,
  output logic                 error_overflow,
  output logic                 error_underflow
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] ALTO_COUNT = (ADDR_BITS+1)'(UMBRAL_ALTO);
  localparam logic [ADDR_BITS:0] BAJO_COUNT = (ADDR_BITS+1)'(UMBRAL_BAJO);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;

  logic push_ok;
  logic pop_ok;
  logic push_drop;
  logic pop_empty;

  assign lleno      = (count == FULL_COUNT);
  assign vacio      = (count == '0);
  assign casi_lleno = (count >= ALTO_COUNT);
  assign casi_vacio = (count <= BAJO_COUNT);

  // A full FIFO still accepts a push when a pop frees a slot in the same
  // cycle; an empty FIFO never bypasses a push straight to the output.
  always_comb begin
    pop_ok    = enb && pop && !vacio;
    push_ok   = enb && push && (!lleno || pop_ok);
    push_drop = enb && push && !push_ok;
    pop_empty = enb && pop && vacio;
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= dato_entrada;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      dato_salida     <= '0;
      valido_salida   <= 1'b0;
      error_overflow  <= 1'b0;
      error_underflow <= 1'b0;
    end else if (enb) begin
      valido_salida <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        dato_salida <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_drop) begin
        error_overflow <= 1'b1;
      end
      if (pop_empty) begin
        error_underflow <= 1'b1;
      end
    end
  end

endmodule
